// File: rtl/seq_oddeven_sorter.sv
// seq_oddeven_sorter
//   Sorts the combined garbler/evaluator vectors (2*NUMVALS unsigned
//   SIZE-bit elements) by odd-even transposition. One layer of
//   compare-exchange cells runs per clock, and the sort takes N = 2*NUMVALS
//   phases. The order (ascending or descending) is chosen at runtime.
//
//   Optional feature: define SORTER_EARLY_EXIT_EN to finish after two
//   consecutive phases with no exchange. If it is not defined, latency is a
//   fixed N cycles and does not depend on the data.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   start    sort request, sampled only in IDLE or DONE
//   desc     order select (0 = ascending, 1 = descending), latched with start
//   g_input  garbler elements; element i maps to array index i
//   e_input  evaluator elements; element i maps to array index NUMVALS+i
//   busy     high while sorting
//   done     high while o holds a valid result
//   o        sorted array; index k at [k*SIZE +: SIZE], k=0 first in order
module seq_oddeven_sorter #(
  parameter int unsigned NUMVALS = 16,
  parameter int unsigned SIZE    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      desc,
  input  logic [NUMVALS*SIZE-1:0]   g_input,
  input  logic [NUMVALS*SIZE-1:0]   e_input,
  output logic                      busy,
  output logic                      done,
  output logic [2*NUMVALS*SIZE-1:0] o
);

  localparam int unsigned N  = 2 * NUMVALS;
  localparam int unsigned PW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [SIZE-1:0]   arr_q [N];
  logic [SIZE-1:0]   arr_d [N];
  logic [PW-1:0]     p_q;
  logic              desc_q;
  logic              busy_q;
  logic              done_q;
  logic [N*SIZE-1:0] o_q;
  logic [N*SIZE-1:0] o_c;
  logic              last_phase_c;
  logic              exit_c;

`ifdef SORTER_EARLY_EXIT_EN
  logic              swapped_c;
  logic              quiet_q;   // the previous completed phase did no exchange
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;

  // One compare-exchange layer. Pairs start at the index whose parity matches
  // the phase, so every pair in a phase is disjoint and reads only arr_q.
  always_comb begin
    arr_d = arr_q;
`ifdef SORTER_EARLY_EXIT_EN
    swapped_c = 1'b0;
`endif
    for (int unsigned j = 0; j + 1 < N; j++) begin
      if (1'(j) == p_q[0]) begin
        if (desc_q ? (arr_q[j] < arr_q[j+1]) : (arr_q[j] > arr_q[j+1])) begin
          arr_d[j]   = arr_q[j+1];
          arr_d[j+1] = arr_q[j];
`ifdef SORTER_EARLY_EXIT_EN
          swapped_c  = 1'b1;
`endif
        end
      end
    end
  end

  // Flatten the post-phase array to the output word.
  always_comb begin
    o_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      o_c[k*SIZE +: SIZE] = arr_d[k];
    end
  end

  // Decide when to finish: always after phase N-1, and optionally earlier
  // once two phases in a row have done no work.
  always_comb begin
    last_phase_c = (p_q == PW'(N - 1));
`ifdef SORTER_EARLY_EXIT_EN
    exit_c = last_phase_c || (quiet_q && !swapped_c);
`else
    exit_c = last_phase_c;
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      desc_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        arr_q[i] <= '0;
      end
`ifdef SORTER_EARLY_EXIT_EN
      quiet_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUMVALS; i++) begin
              arr_q[i]         <= g_input[i*SIZE +: SIZE];
              arr_q[NUMVALS+i] <= e_input[i*SIZE +: SIZE];
            end
            desc_q  <= desc;
            p_q     <= '0;
`ifdef SORTER_EARLY_EXIT_EN
            quiet_q <= 1'b0;
`endif
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= ST_SORT;
          end
        end

        ST_SORT: begin
          arr_q   <= arr_d;
          p_q     <= p_q + PW'(1);
`ifdef SORTER_EARLY_EXIT_EN
          quiet_q <= !swapped_c;
`endif
          if (exit_c) begin
            o_q     <= o_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_oddeven_sorter.md
# seq_oddeven_sorter

Sequential, parametrised successor to our combinational two-party sorter. It merges garbler (`g_input`) and evaluator (`e_input`) vectors into one array of `2*NUMVALS` elements and sorts it by odd-even transposition, one compare-exchange phase per clock. Each phase is one layer of `NUMVALS` comparators instead of an O(N²) unrolled network. It adds runtime ascending/descending order, a start/busy/done handshake, and an optional early exit.

## Interface
- `NUMVALS`, default 16: elements per party; total `N = 2*NUMVALS`, must be ≥ 1.
- `SIZE`, default 32: bits per element, unsigned.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserting it low clears all state immediately.
- `start`, input, 1: request a sort. Sampled only in IDLE or DONE.
- `desc`, input, 1: order select, 0 = ascending, 1 = descending. Latched with `start`.
- `g_input`, input, `NUMVALS*SIZE`: garbler elements. Element i sits at `[i*SIZE +: SIZE]` and maps to array index i.
- `e_input`, input, `NUMVALS*SIZE`: evaluator elements. Element i maps to array index `NUMVALS+i`.
- `busy`, output, 1: high while in SORT.
- `done`, output, 1: high while in DONE; `o` is valid.
- `o`, output, `2*NUMVALS*SIZE`: sorted array. Index k sits at `[k*SIZE +: SIZE]`, with k=0 the smallest (asc) or largest (desc).

## Operation
- **States:** IDLE → SORT → DONE → (SORT on a new `start`) …
- **IDLE:**
  - `start`=1 loads the array from the inputs, latches `desc`, and clears the phase counter `p`.
  - It also clears the swap history. Next state is SORT.
- **SORT:** each cycle applies phase `p`.
  - Even `p` compares pairs (0,1), (2,3), …
  - Odd `p` compares pairs (1,2), (3,4), …
  - A pair (j, j+1) is exchanged iff `a[j] > a[j+1]` (asc) or `a[j] < a[j+1]` (desc).
  - Equal elements are never exchanged.
  - `p` increments; after phase `N-1` completes, next state is DONE.
- **DONE:**
  - `o` holds the result and is stable until the next accepted `start`.
  - `start`=1 reloads the array exactly as in IDLE and goes to SORT.
- **Ignored start:** `start` during SORT has no effect; inputs are not resampled.
- **Input sampling:** `g_input`, `e_input` and `desc` are sampled only on the accepted-`start` edge. Later changes do not affect the running sort.
- **Output register:** `o` is updated only on the edge entering DONE. During SORT it holds the previous result, or 0 after reset.
- **N = 2 (NUMVALS=1):** only phase 0 does work; phase 1 has no pairs. The full sort still takes N = 2 phases.
- **Phase counter width:** `$clog2(N)+1` bits, so no wrap occurs.
- **Reset** (also mid-SORT): state = IDLE, `busy`=0, `done`=0, `o`=0, array=0, `p`=0, latched `desc`=0. Any in-flight sort is discarded.

## Timing
- `start` accepted at edge E0.
- `busy`=1 from E0 through edge E0+N; `done`=1 from edge E0+N onward.
- Full-sort latency: N cycles from accept to `done`.
- A back-to-back `start` in DONE drops `done` and raises `busy` on the same edge.
- Comparisons are evaluated on the registered array only. There is no combinational path from inputs to `o`.
- Critical path: one SIZE-bit comparator plus a mux per pair.

## Configuration
- **`SORTER_EARLY_EXIT_EN` defined:**
  - A per-phase swap flag is kept.
  - When two consecutive completed phases both performed zero exchanges, the array is sorted. The next state is DONE, and `o` loads at that edge.
  - The earliest exit is after phase 1, i.e. `done` at E0+2 for already-ordered input.
  - The N-phase bound still applies.
- **Not defined:**
  - The sorter always runs exactly N phases, giving fixed, data-independent latency.
  - This is the required default for garbled-circuit netlists, where timing must not leak data.

## Test plan
All cases use NUMVALS=4, SIZE=8, so N=8.
- Reset low mid-SORT (cycle 3) → `busy`=0, `done`=0, `o`=0 immediately. After release, state is IDLE and `start` is required again.
- Asc, reverse input:
  - Stimulus: g={8,7,6,5} (idx 0..3), e={4,3,2,1}, `desc`=0.
  - Response: `done` at E0+8, o={1,2,3,4,5,6,7,8}.
- Desc, duplicates and extremes:
  - Stimulus: g={0,255,7,7}, e={255,0,3,7}, `desc`=1.
  - Response: o={255,255,7,7,7,3,0,0}.
- Ignored start and held inputs:
  - Stimulus: `start` pulsed at E0+3 with different inputs and `desc` toggled.
  - Response: the result matches the first request and `done` arrives at E0+8 unchanged.
- Back-to-back:
  - Stimulus: `start` in the DONE cycle with new data.
  - Response: `done` falls and `busy` rises on the same edge. The new result appears 8 cycles later, and the old `o` is held until then.
- Early exit: already-ascending input {1..8} with `SORTER_EARLY_EXIT_EN` → `done` at E0+2. Without the macro → `done` at E0+8, same `o`.
